top_dut: RTL and testbench

//   Two-tap delay line on a single-bit input, used to compare one-stage and
//   two-stage registered paths.

---
 rtl/top_dut.sv | 38 +++
 tb/tb_top_dut.sv | 120 ++++++++++++
 2 files changed

// File: rtl/top_dut.sv
// Two-tap delay line: input a is shifted through a register chain every clock;
// z1 and z2 tap the chain at Z1_DELAY and Z2_DELAY stages.
`timescale 1ns/1ps
module top_dut #(
    parameter int Z1_DELAY = 1,
    parameter int Z2_DELAY = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    output logic z1,
    output logic z2
);

    // Zero-length chains and taps beyond the chain end cannot be built.
    generate
        if (Z1_DELAY < 1 || Z2_DELAY < Z1_DELAY) begin : g_bad_params
            $error("top_dut: need Z1_DELAY >= 1 and Z2_DELAY >= Z1_DELAY");
        end
    endgenerate

    logic [Z2_DELAY-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr[0] <= a;
            for (int i = 1; i < Z2_DELAY; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign z1 = sr[Z1_DELAY-1];
    assign z2 = sr[Z2_DELAY-1];

endmodule

// File: tb/tb_top_dut.sv
// Bench for top_dut: three instances (1/2, 2/4, 1/1) share one stimulus and are
// checked against a history of sampled input values.
`timescale 1ns/1ps
module tb_top_dut;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic a   = 1'b0;
    logic d_z1, d_z2, p_z1, p_z2, e_z1, e_z2;

    int vectors     = 0;
    int miscompares = 0;

    // exp_q[k] is the value of a sampled k+1 rising edges ago since the last reset.
    logic [0:0] exp_q[$];

    top_dut #(.Z1_DELAY(1), .Z2_DELAY(2)) u_def (
        .clk(clk), .rst(rst), .a(a), .z1(d_z1), .z2(d_z2));
    top_dut #(.Z1_DELAY(2), .Z2_DELAY(4)) u_p24 (
        .clk(clk), .rst(rst), .a(a), .z1(p_z1), .z2(p_z2));
    top_dut #(.Z1_DELAY(1), .Z2_DELAY(1)) u_p11 (
        .clk(clk), .rst(rst), .a(a), .z1(e_z1), .z2(e_z2));

    // clock / reset
    always #1 clk = ~clk;

    // reference model: history of sampled inputs, wiped by reset
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            exp_q.push_front(a);
            if (exp_q.size() > 8) exp_q.pop_back();
        end
    end

    function automatic logic exp_tap(input int d);
        if (exp_q.size() >= d) return exp_q[d-1];
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic got, input logic exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at t=%0t: got %b expected %b", tag, $time, got, exp);
        end
    endtask

    task automatic check_all(input string phase);
        check({phase, " def.z1"}, d_z1, exp_tap(1));
        check({phase, " def.z2"}, d_z2, exp_tap(2));
        check({phase, " p24.z1"}, p_z1, exp_tap(2));
        check({phase, " p24.z2"}, p_z2, exp_tap(4));
        check({phase, " p11.z1"}, e_z1, exp_tap(1));
        check({phase, " p11.z2"}, e_z2, exp_tap(1));
    endtask

    task automatic check_zero(input string phase);
        check({phase, " def.z1"}, d_z1, 1'b0);
        check({phase, " def.z2"}, d_z2, 1'b0);
        check({phase, " p24.z1"}, p_z1, 1'b0);
        check({phase, " p24.z2"}, p_z2, 1'b0);
        check({phase, " p11.z1"}, e_z1, 1'b0);
        check({phase, " p11.z2"}, e_z2, 1'b0);
    endtask

    // driver: check outputs at the falling edge, then apply the next input
    task automatic drive_cycle(input string phase, input logic val);
        @(negedge clk);
        check_all(phase);
        a = val;
    endtask

    initial begin
        rst = 1'b1;
        a   = 1'b0;
        @(negedge clk);              // t = 2: first edge at t = 1 was under reset
        check_zero("reset");
        rst = 1'b0;

        // square wave, period 8: a high for 4 time units (2 clocks), low for 2 clocks
        for (int i = 0; i < 12; i++) begin
            drive_cycle("square", ((i % 4) < 2) ? 1'b1 : 1'b0);
        end

        // load ones so z1 is high, then reset between edges
        drive_cycle("preload", 1'b1);
        drive_cycle("preload", 1'b1);
        drive_cycle("preload", 1'b1);
        @(posedge clk);
        #0.5;
        check("pre-rst def.z1 high", d_z1, 1'b1);
        rst = 1'b1;
        #0.1;
        check_zero("async rst");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_zero("rst held");
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) drive_cycle("refill", 1'b1);

        // single-cycle pulse through a zeroed pipeline
        for (int i = 0; i < 5; i++) drive_cycle("flush", 1'b0);
        drive_cycle("pulse", 1'b1);
        for (int i = 0; i < 7; i++) drive_cycle("pulse", 1'b0);

        // random stimulus
        for (int i = 0; i < 200; i++) begin
            drive_cycle("random", 1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        check_all("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
